// File: rtl/num_sep_session_ctrl.sv
// num_sep_session_ctrl: runs one separator parse session (clear, wait, drain)
// and streams the stored numbers to the matrix loader over valid/ready.
module num_sep_session_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 11,
    parameter int RD_LATENCY     = 1,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  sep_buf_clear,
    input  logic                  sep_done,
    input  logic                  sep_invalid,
    input  logic [10:0]           sep_num_count,
    output logic [ADDR_WIDTH-1:0] sep_rd_addr,
    input  logic [DATA_WIDTH-1:0] sep_rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [10:0]           count,
    output logic [1:0]            status,
    output logic                  status_valid
);

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_INVALID = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_ABORT   = 2'd3;

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LATENCY - 1);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = ADDR_WIDTH'(1);
    localparam logic [31:0] CAP = 32'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT,
        S_READ,
        S_LAT,
        S_PRESENT,
        S_FINISH
    } state_t;

    state_t                 state_q, state_d;
    logic                   armed_q, armed_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [LAT_W-1:0]       lat_q, lat_d;
    logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [10:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic [1:0]             status_q, status_d;
    logic                   clear_q, clear_d;
    logic                   pulse_q, pulse_d;

    logic                   abort_hit;
    logic                   idx_last;
    logic [10:0]            num_clamp;
    logic                   fin;
    logic [1:0]             fin_code;

    // The RAM cannot hold more than 2**ADDR_WIDTH words.
    assign num_clamp = ({21'd0, sep_num_count} > CAP) ? CAP[10:0]
                                                       : sep_num_count;
    assign idx_last  = (32'(idx_q) + 32'd1) == 32'(count_q);
    assign abort_hit = abort && (state_q != S_IDLE)
                             && (state_q != S_FINISH);

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        tmo_d     = tmo_q;
        lat_d     = lat_q;
        idx_d     = idx_q;
        rd_addr_d = rd_addr_q;
        count_d   = count_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        status_d  = status_q;
        clear_d   = 1'b0;
        pulse_d   = 1'b0;
        fin       = 1'b0;
        fin_code  = ST_OK;

        if (abort_hit) begin
            fin      = 1'b1;
            fin_code = ST_ABORT;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_d = S_CLEAR;
                        clear_d = 1'b1;
                    end
                end
                S_CLEAR: begin
                    armed_d = 1'b0;
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    tmo_d = tmo_q + TMO_ONE;
                    // Flags left over from the previous session must drop first.
                    if (!sep_done && !sep_invalid) begin
                        armed_d = 1'b1;
                    end
                    if (armed_q && sep_invalid) begin
                        fin      = 1'b1;
                        fin_code = ST_INVALID;
                    end else if (armed_q && sep_done) begin
                        count_d = num_clamp;
                        if (num_clamp == 11'd0) begin
                            fin = 1'b1;
                        end else begin
                            idx_d     = '0;
                            rd_addr_d = '0;
                            state_d   = S_READ;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        fin      = 1'b1;
                        fin_code = ST_TIMEOUT;
                    end
                end
                S_READ: begin
                    lat_d   = '0;
                    state_d = S_LAT;
                end
                S_LAT: begin
                    if (lat_q == LAT_LAST) begin
                        data_d  = sep_rd_data;
                        valid_d = 1'b1;
                        last_d  = idx_last;
                        state_d = S_PRESENT;
                    end else begin
                        lat_d = lat_q + LAT_ONE;
                    end
                end
                S_PRESENT: begin
                    if (out_ready) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        if (last_q) begin
                            fin = 1'b1;
                        end else begin
                            idx_d     = idx_q + IDX_ONE;
                            rd_addr_d = idx_q + IDX_ONE;
                            state_d   = S_READ;
                        end
                    end
                end
                S_FINISH: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if (fin) begin
            state_d  = S_FINISH;
            status_d = fin_code;
            pulse_d  = 1'b1;
            valid_d  = 1'b0;
            last_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            armed_q   <= 1'b0;
            tmo_q     <= '0;
            lat_q     <= '0;
            idx_q     <= '0;
            rd_addr_q <= '0;
            count_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            status_q  <= ST_OK;
            clear_q   <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            tmo_q     <= tmo_d;
            lat_q     <= lat_d;
            idx_q     <= idx_d;
            rd_addr_q <= rd_addr_d;
            count_q   <= count_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            status_q  <= status_d;
            clear_q   <= clear_d;
            pulse_q   <= pulse_d;
        end
    end

    assign sep_buf_clear = clear_q;
    assign sep_rd_addr   = rd_addr_q;
    assign out_data      = data_q;
    assign out_valid     = valid_q;
    assign out_last      = last_q;
    assign busy          = (state_q != S_IDLE);
    assign count         = count_q;
    assign status        = status_q;
    assign status_valid  = pulse_q;

endmodule

// File: tb/tb_num_sep_session_ctrl.sv
// Bench for num_sep_session_ctrl: random sessions against a queue-based
// model of what the matrix loader should receive and which status results.
module tb_num_sep_session_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int RL    = 1;
    localparam int TMO   = 16;
    localparam int DEPTH = 1 << AW;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_INVALID = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_ABORT   = 2'd3;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } xfer_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          sep_buf_clear;
    logic          sep_done;
    logic          sep_invalid;
    logic [10:0]   sep_num_count;
    logic [AW-1:0] sep_rd_addr;
    logic [DW-1:0] sep_rd_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic          busy;
    logic [10:0]   count;
    logic [1:0]    status;
    logic          status_valid;

    logic [DW-1:0] mem [DEPTH];
    xfer_t         exp_q[$];
    logic [1:0]    exp_st[$];

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int st_cnt   = 0;
    int xfer_cnt = 0;
    int clr_cnt  = 0;
    int rdy_mode = 0;
    bit thru_chk = 1'b0;

    num_sep_session_ctrl #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .RD_LATENCY    (RL),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .sep_buf_clear(sep_buf_clear),
        .sep_done     (sep_done),
        .sep_invalid  (sep_invalid),
        .sep_num_count(sep_num_count),
        .sep_rd_addr  (sep_rd_addr),
        .sep_rd_data  (sep_rd_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .busy         (busy),
        .count        (count),
        .status       (status),
        .status_valid (status_valid)
    );

    always #5 clk = ~clk;

    // Separator RAM: synchronous read, one cycle of latency.
    always @(posedge clk) sep_rd_data <= mem[sep_rd_addr];

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = ~out_ready;
            endcase
        end
    end

    // Scoreboard monitor.
    initial begin
        bit            hold_v;
        logic [DW-1:0] hold_d;
        logic          hold_l;
        int            prev_hs;
        xfer_t         e;
        logic [1:0]    es;
        hold_v  = 1'b0;
        hold_d  = '0;
        hold_l  = 1'b0;
        prev_hs = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                hold_v  = 1'b0;
                prev_hs = -1;
            end else begin
                if (sep_buf_clear) clr_cnt++;
                if (hold_v) begin
                    checks++;
                    if (!out_valid || out_data !== hold_d || out_last !== hold_l) begin
                        errors++;
                        $display("FAIL hold: got v=%0b d=%0h l=%0b, expected v=1 d=%0h l=%0b",
                                 out_valid, out_data, out_last, hold_d, hold_l);
                    end
                end
                hold_v = out_valid && !out_ready && !abort;
                hold_d = out_data;
                hold_l = out_last;
                if (out_valid && out_ready && !abort) begin
                    xfer_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL xfer: got unexpected d=%0h l=%0b, expected none",
                                 out_data, out_last);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_data !== e.d || out_last !== e.l) begin
                            errors++;
                            $display("FAIL xfer: got d=%0h l=%0b, expected d=%0h l=%0b",
                                     out_data, out_last, e.d, e.l);
                        end
                    end
                    if (thru_chk && prev_hs >= 0) begin
                        checks++;
                        if (cyc - prev_hs != RL + 2) begin
                            errors++;
                            $display("FAIL throughput: got gap %0d, expected %0d",
                                     cyc - prev_hs, RL + 2);
                        end
                    end
                    prev_hs = cyc;
                end
                if (status_valid) begin
                    st_cnt++;
                    prev_hs = -1;
                    checks++;
                    if (exp_st.size() == 0) begin
                        errors++;
                        $display("FAIL status: got unexpected pulse %0d, expected none", status);
                    end else begin
                        es = exp_st.pop_front();
                        if (status !== es) begin
                            errors++;
                            $display("FAIL status: got %0d, expected %0d", status, es);
                        end
                    end
                    checks++;
                    if (exp_q.size() != 0) begin
                        errors++;
                        $display("FAIL missing_xfer: got %0d left, expected 0", exp_q.size());
                        exp_q.delete();
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input int s0, input int budget);
        for (int i = 0; i < budget && st_cnt == s0; i++) tick();
        if (st_cnt == s0) begin
            checks++;
            errors++;
            $display("FAIL session_end: got no status in %0d cycles, expected one", budget);
        end
    endtask

    task automatic check_reset_outputs(input string p);
        chk({p, "_out_valid"}, 32'(out_valid), 0);
        chk({p, "_out_last"}, 32'(out_last), 0);
        chk({p, "_out_data"}, out_data, 0);
        chk({p, "_busy"}, 32'(busy), 0);
        chk({p, "_clear"}, 32'(sep_buf_clear), 0);
        chk({p, "_status_valid"}, 32'(status_valid), 0);
        chk({p, "_status"}, 32'(status), 0);
        chk({p, "_count"}, 32'(count), 0);
        chk({p, "_rd_addr"}, 32'(sep_rd_addr), 0);
    endtask

    task automatic fill_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    endtask

    // Successful session: the loader must see the first min(n, DEPTH) words.
    task automatic run_ok(input int n, input int dly, input bit stale, input bit poke);
        int    m;
        int    c0;
        int    s0;
        xfer_t e;
        m  = (n > DEPTH) ? DEPTH : n;
        c0 = clr_cnt;
        sep_invalid = 1'b0;
        if (stale) begin
            sep_done      = 1'b1;
            sep_num_count = 11'(n + 3);
        end else begin
            sep_done = 1'b0;
        end
        pulse_start();
        chk("busy_after_start", 32'(busy), 1);
        tick();
        if (stale) begin
            tick();
            sep_done = 1'b0;
            tick();
        end
        repeat (dly) tick();
        s0 = st_cnt;
        for (int i = 0; i < m; i++) begin
            e.d = mem[i];
            e.l = (i == m - 1);
            exp_q.push_back(e);
        end
        exp_st.push_back(ST_OK);
        sep_num_count = 11'(n);
        sep_done      = 1'b1;
        if (poke) begin
            tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        wait_end(s0, 800);
        chk("count", 32'(count), 32'(m));
        chk("clear_once", 32'(clr_cnt - c0), 1);
        chk("status_hold", 32'(status), 32'(ST_OK));
        chk("idle_busy", 32'(busy), 0);
    endtask

    task automatic run_invalid(input bit with_done);
        int s0;
        sep_done    = 1'b0;
        sep_invalid = 1'b0;
        pulse_start();
        tick();
        tick();
        s0 = st_cnt;
        exp_st.push_back(ST_INVALID);
        sep_num_count = 11'd5;
        sep_invalid   = 1'b1;
        sep_done      = with_done;
        wait_end(s0, 100);
        chk("invalid_hold", 32'(status), 32'(ST_INVALID));
        sep_invalid = 1'b0;
        sep_done    = 1'b0;
    endtask

    task automatic run_timeout();
        int lat;
        sep_done    = 1'b0;
        sep_invalid = 1'b0;
        pulse_start();
        tick();
        exp_st.push_back(ST_TIMEOUT);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (status_valid) begin
                lat = i;
                break;
            end
        end
        chk("timeout_latency", 32'(lat), 32'(TMO));
        tick();
        chk("timeout_idle", 32'(busy), 0);
    endtask

    task automatic run_abort_stream();
        int    x0;
        bit    found;
        xfer_t e;
        rdy_mode = 2;
        thru_chk = 1'b0;
        fill_mem();
        sep_done    = 1'b0;
        sep_invalid = 1'b0;
        pulse_start();
        tick();
        tick();
        x0 = xfer_cnt;
        for (int i = 0; i < 2; i++) begin
            e.d = mem[i];
            e.l = 1'b0;
            exp_q.push_back(e);
        end
        exp_st.push_back(ST_ABORT);
        sep_num_count = 11'd4;
        sep_done      = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (xfer_cnt - x0 >= 2 && out_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort_third_present", 32'(found), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid_drop", 32'(out_valid), 0);
        chk("abort_last_drop", 32'(out_last), 0);
        chk("abort_pulse", 32'(status_valid), 1);
        chk("abort_status", 32'(status), 32'(ST_ABORT));
        tick();
        chk("abort_xfers", 32'(xfer_cnt - x0), 2);
        chk("abort_idle", 32'(busy), 0);
    endtask

    task automatic run_abort_wait();
        sep_done    = 1'b0;
        sep_invalid = 1'b0;
        pulse_start();
        tick();
        tick();
        exp_st.push_back(ST_ABORT);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_wait_pulse", 32'(status_valid), 1);
        chk("abort_wait_status", 32'(status), 32'(ST_ABORT));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_finish", 32'(busy), 0);
    endtask

    task automatic run_reset_mid();
        int    x0;
        int    s0;
        bit    found;
        xfer_t e;
        rdy_mode = 0;
        thru_chk = 1'b0;
        fill_mem();
        sep_done    = 1'b0;
        sep_invalid = 1'b0;
        tick();
        pulse_start();
        tick();
        tick();
        x0 = xfer_cnt;
        s0 = st_cnt;
        for (int i = 0; i < 10; i++) begin
            e.d = mem[i];
            e.l = (i == 9);
            exp_q.push_back(e);
        end
        exp_st.push_back(ST_OK);
        sep_num_count = 11'd10;
        sep_done      = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (xfer_cnt - x0 >= 3) begin
                found = 1'b1;
                break;
            end
        end
        chk("reset_mid_progress", 32'(found), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        exp_q.delete();
        exp_st.delete();
        sep_done = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("reset_no_status", 32'(st_cnt - s0), 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        sep_done      = 1'b0;
        sep_invalid   = 1'b0;
        sep_num_count = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 0);
        repeat (3) tick();
        chk("idle_abort_no_status", 32'(st_cnt), 0);

        rdy_mode = 0;
        thru_chk = 1'b1;
        tick();
        mem[0] = 32'd7;
        mem[1] = 32'hFFFF_FFFE;
        mem[2] = 32'd100;
        run_ok(3, 5, 1'b0, 1'b0);

        fill_mem();
        run_ok(2, 3, 1'b1, 1'b0);

        run_invalid(1'b1);
        run_timeout();
        run_abort_stream();

        rdy_mode = 0;
        thru_chk = 1'b1;
        tick();
        run_ok(0, 2, 1'b0, 1'b1);
        fill_mem();
        run_ok(DEPTH, 1, 1'b0, 1'b0);
        fill_mem();
        run_ok(DEPTH + 1, 4, 1'b1, 1'b0);
        fill_mem();
        run_ok(2047, 8, 1'b0, 1'b1);
        fill_mem();
        run_ok(1, 1, 1'b0, 1'b0);

        run_reset_mid();

        for (int it = 0; it < 24; it++) begin
            int kind;
            int r;
            int n;
            kind     = $urandom_range(0, 9);
            rdy_mode = $urandom_range(0, 1);
            thru_chk = (rdy_mode == 0);
            tick();
            if (kind <= 6) begin
                r = $urandom_range(0, 4);
                if (r == 0) n = 0;
                else if (r == 1) n = $urandom_range(DEPTH + 1, 2047);
                else n = $urandom_range(1, DEPTH);
                fill_mem();
                run_ok(n, $urandom_range(1, 8),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else if (kind == 7) begin
                run_invalid(1'($urandom_range(0, 1)));
            end else begin
                run_abort_wait();
            end
        end

        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
